// File: rtl/run_step_controller.sv
// ---------------------------------------------------------------------------
// run_step_controller
//
// Clock-enable sequencer for the CPU core. It turns the board controls into a
// one-cycle cpu_en pulse stream: free-run from a switch, single-step from a
// push key, or paused. A CPU halt request is latched until the run switch is
// cleared. The current mode and the number of issued enables drive the
// LEDR/HEX display.
//
// Ports
//   clk          in   system clock
//   reset        in   asynchronous, active-high reset
//   run_mode     in   run switch level, 1 = free-run (asynchronous pin)
//   step_key_n   in   step key level, active-low and bouncy (asynchronous pin)
//   halt_req     in   CPU halt level, already synchronous to clk
//   cpu_en       out  CPU clock enable, one-cycle pulses
//   mode         out  0 = PAUSE, 1 = RUN, 2 = STEP, 3 = HALT
//   cycle_count  out  number of cpu_en pulses issued, wraps
// ---------------------------------------------------------------------------
module run_step_controller #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int PRESCALE        = 1,
    parameter int CNT_W           = 24
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run_mode,
    input  logic             step_key_n,
    input  logic             halt_req,
    output logic             cpu_en,
    output logic [1:0]       mode,
    output logic [CNT_W-1:0] cycle_count
);

    localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

    typedef enum logic [1:0] {
        ST_PAUSE = 2'd0,
        ST_RUN   = 2'd1,
        ST_STEP  = 2'd2,
        ST_HALT  = 2'd3
    } state_t;

    // -----------------------------------------------------------------------
    // Two-flop synchronisers for the asynchronous board pins. The key idles
    // high (released), so its flops reset to 1 to avoid a fake press.
    // -----------------------------------------------------------------------
    logic r_run_meta, r_run_s;
    logic r_key_meta, r_key_s;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_run_meta <= 1'b0;
            r_run_s    <= 1'b0;
            r_key_meta <= 1'b1;
            r_key_s    <= 1'b1;
        end else begin
            r_run_meta <= run_mode;
            r_run_s    <= r_run_meta;
            r_key_meta <= step_key_n;
            r_key_s    <= r_key_meta;
        end
    end

    // -----------------------------------------------------------------------
    // Key debounce: the accepted level only follows the synced key after it
    // has disagreed for DEBOUNCE_CYCLES consecutive cycles. Any agreeing
    // cycle restarts the count, so short bounces are swallowed.
    // -----------------------------------------------------------------------
    logic [DB_W-1:0] r_db_cnt;
    logic            r_key_db;
    logic            r_key_db_d;
    logic            w_key_mismatch;
    logic            w_step_evt;

    assign w_key_mismatch = (r_key_s != r_key_db);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_db_cnt   <= '0;
            r_key_db   <= 1'b1;
            r_key_db_d <= 1'b1;
        end else begin
            r_key_db_d <= r_key_db;
            if (!w_key_mismatch) begin
                r_db_cnt <= '0;
            end else if (r_db_cnt == DB_LAST) begin
                r_key_db <= r_key_s;
                r_db_cnt <= '0;
            end else begin
                r_db_cnt <= r_db_cnt + DB_W'(1);
            end
        end
    end

    // One-cycle pulse on the press edge only; release does nothing.
    assign w_step_evt = r_key_db_d & ~r_key_db;

    // -----------------------------------------------------------------------
    // Mode FSM
    // -----------------------------------------------------------------------
    state_t r_state;
    state_t w_next;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_PAUSE;
        end else begin
            r_state <= w_next;
        end
    end

    // A step event that arrives outside PAUSE is simply dropped.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_PAUSE: begin
                if (r_run_s)         w_next = ST_RUN;
                else if (w_step_evt) w_next = ST_STEP;
            end
            ST_RUN: begin
                if (halt_req)        w_next = ST_HALT;
                else if (!r_run_s)   w_next = ST_PAUSE;
            end
            ST_STEP: begin
                // Exactly one cycle in STEP.
                if (halt_req)        w_next = ST_HALT;
                else                 w_next = ST_PAUSE;
            end
            ST_HALT: begin
                if (!r_run_s)        w_next = ST_PAUSE;
            end
            default:                 w_next = ST_PAUSE;
        endcase
    end

    // -----------------------------------------------------------------------
    // Prescaler: only advances while staying in RUN, so it is 0 in the first
    // RUN cycle and is cleared by the same edge that leaves RUN.
    // -----------------------------------------------------------------------
    logic [PS_W-1:0] r_presc;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_presc <= '0;
        end else if (r_state == ST_RUN && w_next == ST_RUN) begin
            r_presc <= (r_presc == PS_LAST) ? '0 : r_presc + PS_W'(1);
        end else begin
            r_presc <= '0;
        end
    end

    // Decoded from registers only, so the enable cannot glitch and falls as
    // soon as reset is asserted.
    logic w_cpu_en;
    assign w_cpu_en = (r_state == ST_STEP) |
                      ((r_state == ST_RUN) & (r_presc == PS_LAST));

    // -----------------------------------------------------------------------
    // Executed-cycle counter. A pulse issued in the cycle that RUN moves to
    // HALT is still counted, since counting depends only on w_cpu_en.
    // -----------------------------------------------------------------------
    logic [CNT_W-1:0] r_cycle_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cycle_count <= '0;
        end else if (w_cpu_en) begin
            r_cycle_count <= r_cycle_count + CNT_W'(1);
        end
    end

    assign cpu_en      = w_cpu_en;
    assign mode        = r_state;
    assign cycle_count = r_cycle_count;

endmodule

// File: tb/tb_run_step_controller.sv
module tb_run_step_controller;

    localparam int DB = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       run_mode = 1'b0;
    logic       step_key_n = 1'b1;
    logic       halt_req = 1'b0;

    logic       en1, en4;
    logic [1:0] mode1, mode4;
    logic [7:0] cnt1;
    logic [3:0] cnt4;

    always #5 clk = ~clk;

    // PRESCALE=1 instance with a short counter so random runs exercise wrap.
    run_step_controller #(.DEBOUNCE_CYCLES(DB), .PRESCALE(1), .CNT_W(8)) dut1 (
        .clk(clk), .reset(reset), .run_mode(run_mode), .step_key_n(step_key_n),
        .halt_req(halt_req), .cpu_en(en1), .mode(mode1), .cycle_count(cnt1));

    run_step_controller #(.DEBOUNCE_CYCLES(DB), .PRESCALE(4), .CNT_W(4)) dut4 (
        .clk(clk), .reset(reset), .run_mode(run_mode), .step_key_n(step_key_n),
        .halt_req(halt_req), .cpu_en(en4), .mode(mode4), .cycle_count(cnt4));

    typedef struct {
        logic [1:0] mode;
        logic       en1;
        logic [7:0] c1;
        logic       en4;
        logic [3:0] c4;
    } exp_t;

    exp_t exp_q[$];
    int   n_total = 0;
    int   n_pass  = 0;
    bit   mon_en  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp, input int cyc);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s cycle %0d: got %0d expected %0d", nm, cyc, act, exp);
    endtask

    // ---------------- reference model ----------------
    // Sync pins are modelled as a two-deep delay line; the debounced key is a
    // level that flips after DB consecutive disagreeing samples; RUN pulses
    // fire on every P-th cycle of a RUN stretch (1-based).
    int         m_run_a, m_run_s, m_key_a, m_key_s;
    int         m_db, m_mis, m_evt, m_mode, m_nrun, cyc;
    logic [7:0] m_cnt1;
    logic [3:0] m_cnt4;

    function automatic bit m_en(input int p);
        return (m_mode == 2) || (m_mode == 1 && (m_nrun % p) == 0);
    endfunction

    task automatic model_reset();
        m_run_a = 0; m_run_s = 0; m_key_a = 1; m_key_s = 1;
        m_db = 1; m_mis = 0; m_evt = 0; m_mode = 0; m_nrun = 0;
        m_cnt1 = '0; m_cnt4 = '0;
    endtask

    task automatic model_edge();
        int nm, new_evt;
        bit e1, e4;
        if (reset) begin model_reset(); return; end
        e1 = m_en(1);
        e4 = m_en(4);
        case (m_mode)
            0: nm = m_run_s ? 1 : (m_evt ? 2 : 0);
            1: nm = halt_req ? 3 : (!m_run_s ? 0 : 1);
            2: nm = halt_req ? 3 : 0;
            default: nm = !m_run_s ? 0 : 3;
        endcase
        m_nrun = (nm == 1) ? ((m_mode == 1) ? m_nrun + 1 : 1) : 0;
        m_cnt1 = m_cnt1 + 8'(e1);
        m_cnt4 = m_cnt4 + 4'(e4);
        new_evt = 0;
        if (m_key_s != m_db) begin
            m_mis++;
            if (m_mis == DB) begin
                if (m_db == 1) new_evt = 1;
                m_db  = m_key_s;
                m_mis = 0;
            end
        end else begin
            m_mis = 0;
        end
        m_run_s = m_run_a; m_run_a = int'(run_mode);
        m_key_s = m_key_a; m_key_a = int'(step_key_n);
        m_evt  = new_evt;
        m_mode = nm;
    endtask

    task automatic push_exp();
        exp_t e;
        e.mode = 2'(m_mode);
        e.en1  = m_en(1);
        e.c1   = m_cnt1;
        e.en4  = m_en(4);
        e.c4   = m_cnt4;
        exp_q.push_back(e);
        mon_en = 1;
    endtask

    // One clock: model follows the edge, then new inputs are driven mid-cycle
    // (reset included, so an async reset is expected before the next edge).
    task automatic tick(input logic rm, input logic key, input logic hr, input logic rs);
        @(posedge clk);
        model_edge();
        cyc++;
        #1;
        run_mode = rm; step_key_n = key; halt_req = hr; reset = rs;
        if (rs) model_reset();
        push_exp();
    endtask

    task automatic ticks(input int n, input logic rm, input logic key, input logic hr);
        for (int i = 0; i < n; i++) tick(rm, key, hr, 1'b0);
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (mon_en) begin
            if (exp_q.size() == 0) begin
                chk("queue_underflow", 32'd1, 32'd0, cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("mode1", 32'(mode1), 32'(e.mode), cyc);
                chk("mode4", 32'(mode4), 32'(e.mode), cyc);
                chk("cpu_en_p1", 32'(en1), 32'(e.en1), cyc);
                chk("cpu_en_p4", 32'(en4), 32'(e.en4), cyc);
                chk("count_p1", 32'(cnt1), 32'(e.c1), cyc);
                chk("count_p4", 32'(cnt4), 32'(e.c4), cyc);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic rm, key, hr, rs;
        cyc = 0;
        model_reset();
        // reset held 3 cycles, then idle
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b1, 1'b0, 1'b1);
        ticks(20, 1'b0, 1'b1, 1'b0);
        // free run, then pause with count frozen
        ticks(12, 1'b1, 1'b1, 1'b0);
        ticks(8, 1'b0, 1'b1, 1'b0);
        // longer run for the PRESCALE=4 spacing
        ticks(20, 1'b1, 1'b1, 1'b0);
        ticks(6, 1'b0, 1'b1, 1'b0);
        // short bounce (ignored), then a real press
        ticks(2, 1'b0, 1'b0, 1'b0);
        ticks(10, 1'b0, 1'b1, 1'b0);
        ticks(10, 1'b0, 1'b0, 1'b0);
        ticks(10, 1'b0, 1'b1, 1'b0);
        // halt from RUN, press ignored in HALT, leave via run switch
        ticks(7, 1'b1, 1'b1, 1'b0);
        ticks(3, 1'b1, 1'b1, 1'b1);
        ticks(10, 1'b1, 1'b0, 1'b0);
        ticks(5, 1'b1, 1'b1, 1'b0);
        ticks(6, 1'b0, 1'b1, 1'b0);
        // press while halt_req high in PAUSE: halt ignored, STEP then HALT
        ticks(12, 1'b0, 1'b0, 1'b1);
        ticks(4, 1'b0, 1'b1, 1'b0);
        // reset mid-RUN with run switch still high
        ticks(9, 1'b1, 1'b1, 1'b0);
        tick(1'b1, 1'b1, 1'b0, 1'b1);
        ticks(8, 1'b1, 1'b1, 1'b0);
        // long run to wrap the 4-bit counter
        ticks(80, 1'b1, 1'b1, 1'b0);
        ticks(4, 1'b0, 1'b1, 1'b0);
        // random phase
        rm = 1'b0; key = 1'b1; hr = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 19) == 0) rm = ~rm;
            if ($urandom_range(0, 5) == 0) key = ~key;
            if ($urandom_range(0, 24) == 0) hr = ~hr;
            rs = ($urandom_range(0, 399) == 0);
            tick(rm, key, hr, rs);
        end
        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
